// File: rtl/io_sequencer_pkg.sv
// rtl/io_sequencer_pkg.sv - shared states, IO mode encodings and defaults for io_sequencer
package io_sequencer_pkg;

  localparam int SETTLE_CYCLES_DEF = 7;

  // Width of the shared cycle_timer; bounds SETTLE_CYCLES and DEC_TIMEOUT.
  localparam int TMR_W = 16;

  localparam logic [1:0] WRLD_IDLE = 2'b00;
  localparam logic [1:0] WRLD_RAM  = 2'b01;
  localparam logic [1:0] WRLD_DEC  = 2'b10;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_FEED     = 3'd2;
  localparam logic [2:0] ST_WAIT_DEC = 3'd3;
  localparam logic [2:0] ST_SETTLE   = 3'd4;
  localparam logic [2:0] ST_FIRE     = 3'd5;

endpackage

// File: rtl/io_sequencer_cycle_timer.sv
// rtl/io_sequencer_cycle_timer.sv - loadable down-counter with a zero/done flag
module cycle_timer #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_done
);

  logic [W-1:0] r_count;

  // Load wins over decrement; the count parks at zero rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/io_sequencer.sv
// rtl/io_sequencer.sv - CPU-to-IO transfer sequencer driving decompressor feed and ODE fire
module io_sequencer
  import io_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int DEC_TIMEOUT   = 255,
  parameter int CNT_W         = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_cpu_valid,
  output logic             o_cpu_ready,
  input  logic             i_io_finished,
  input  logic             i_decomp_done,
  output logic             o_demux_sel,
  output logic             o_io_new,
  output logic [1:0]       o_wrld,
  output logic             o_ode_enable,
  output logic             o_busy,
  output logic             o_error,
  output logic [CNT_W-1:0] o_words_fed
);

  // Timer is loaded one below the cycle count: a value of N-1 reaches zero
  // on the N-th cycle spent in the timed state, which is when we leave it.
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DEC_LD    = TMR_W'(DEC_TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic             r_demux_sel;
  logic [1:0]       r_wrld;
  logic             r_ode_enable;
  logic             r_busy;
  logic             r_error;
  logic [CNT_W-1:0] r_words_fed;

  logic             w_accept_start;
  logic             w_feed_hs;
  logic             w_timeout;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_dec;
  logic             w_tmr_done;
  logic             w_next_dec_mode;

  assign w_accept_start = (r_state == ST_IDLE) && i_start && i_cpu_valid;
  assign w_feed_hs      = (r_state == ST_FEED) && i_cpu_valid;

  // Handshake decodes stay combinational so the CPU sees ready in the same cycle.
  assign o_cpu_ready = !i_rst && (((r_state == ST_IDLE) && i_start) || (r_state == ST_FEED));
  assign o_io_new    = !i_rst && (w_accept_start || w_feed_hs);

  // Next-state decode; the shared timer is (re)loaded on entry to each timed state.
  always_comb begin
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    w_timeout  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept_start) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (i_io_finished) begin
          w_next     = ST_SETTLE;
          w_tmr_load = 1'b1;
          w_tmr_val  = SETTLE_LD;
        end else begin
          w_next = ST_FEED;
        end
      end
      ST_FEED: begin
        if (i_cpu_valid) begin
          w_next     = ST_WAIT_DEC;
          w_tmr_load = 1'b1;
          w_tmr_val  = DEC_LD;
        end
      end
      ST_WAIT_DEC: begin
        // A completion arriving on the timeout cycle still counts as success.
        if (i_decomp_done) begin
          if (i_io_finished) begin
            w_next     = ST_SETTLE;
            w_tmr_load = 1'b1;
            w_tmr_val  = SETTLE_LD;
          end else begin
            w_next = ST_FEED;
          end
        end else if (w_tmr_done) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (w_tmr_done) w_next = ST_FIRE;
      end
      ST_FIRE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign w_tmr_dec       = (r_state == ST_SETTLE) || (r_state == ST_WAIT_DEC);
  assign w_next_dec_mode = (w_next == ST_FEED) || (w_next == ST_WAIT_DEC);

  cycle_timer #(
    .W (TMR_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_done     (w_tmr_done)
  );

  // State plus registered outputs, computed from the next state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_demux_sel  <= 1'b0;
      r_wrld       <= WRLD_IDLE;
      r_ode_enable <= 1'b0;
      r_busy       <= 1'b0;
      r_error      <= 1'b0;
      r_words_fed  <= '0;
    end else begin
      r_state      <= w_next;
      r_demux_sel  <= w_next_dec_mode;
      r_wrld       <= w_next_dec_mode ? WRLD_DEC : WRLD_IDLE;
      r_ode_enable <= (w_next == ST_FIRE);
      r_busy       <= (w_next != ST_IDLE);
      if (w_accept_start) begin
        r_error <= 1'b0;
      end else if (w_timeout) begin
        r_error <= 1'b1;
      end
      if (w_accept_start) begin
        r_words_fed <= '0;
      end else if (w_feed_hs) begin
        r_words_fed <= r_words_fed + 1'b1;
      end
    end
  end

  assign o_demux_sel  = r_demux_sel;
  assign o_wrld       = r_wrld;
  assign o_ode_enable = r_ode_enable;
  assign o_busy       = r_busy;
  assign o_error      = r_error;
  assign o_words_fed  = r_words_fed;

endmodule

// File: tb/tb_io_sequencer.sv
// tb/tb_io_sequencer.sv - directed self-checking bench for io_sequencer
module tb_io_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_cpu_valid;
  logic        o_cpu_ready;
  logic        i_io_finished;
  logic        i_decomp_done;
  logic        o_demux_sel;
  logic        o_io_new;
  logic [1:0]  o_wrld;
  logic        o_ode_enable;
  logic        o_busy;
  logic        o_error;
  logic [15:0] o_words_fed;

  int n_checks = 0;
  int n_errors = 0;
  int n;
  int ode_seen;

  io_sequencer #(
    .SETTLE_CYCLES (7),
    .DEC_TIMEOUT   (255),
    .CNT_W         (16)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_cpu_valid   (i_cpu_valid),
    .o_cpu_ready   (o_cpu_ready),
    .i_io_finished (i_io_finished),
    .i_decomp_done (i_decomp_done),
    .o_demux_sel   (o_demux_sel),
    .o_io_new      (o_io_new),
    .o_wrld        (o_wrld),
    .o_ode_enable  (o_ode_enable),
    .o_busy        (o_busy),
    .o_error       (o_error),
    .o_words_fed   (o_words_fed)
  );

  always #5 i_clk = ~i_clk;

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    #1;
    chk({tag, "_ready"}, 32'(o_cpu_ready), 0);
    chk({tag, "_new"},   32'(o_io_new), 0);
    chk({tag, "_demux"}, 32'(o_demux_sel), 0);
    chk({tag, "_wrld"},  32'(o_wrld), 0);
    chk({tag, "_ode"},   32'(o_ode_enable), 0);
    chk({tag, "_busy"},  32'(o_busy), 0);
    chk({tag, "_err"},   32'(o_error), 0);
    chk({tag, "_wf"},    32'(o_words_fed), 0);
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_cpu_valid = 1'b0;
    i_io_finished = 1'b0; i_decomp_done = 1'b0;
    cyc(); cyc();
    chk_reset_vals("rst");
    i_start = 1'b1; i_cpu_valid = 1'b1;
    #1;
    chk("rst_prio_ready", 32'(o_cpu_ready), 0);
    chk("rst_prio_new", 32'(o_io_new), 0);
    cyc();
    chk("rst_prio_busy", 32'(o_busy), 0);
    i_rst = 1'b0; i_start = 1'b0; i_cpu_valid = 1'b0;
    cyc();

    // Count transfer of three words, completion 4 cycles after each feed
    i_start = 1'b1; i_cpu_valid = 1'b1;
    #1;
    chk("hs_ready", 32'(o_cpu_ready), 1);
    chk("hs_new", 32'(o_io_new), 1);
    chk("hs_demux", 32'(o_demux_sel), 0);
    cyc();
    i_start = 1'b0; i_cpu_valid = 1'b0;
    #1;
    chk("load_busy", 32'(o_busy), 1);
    chk("load_demux", 32'(o_demux_sel), 0);
    chk("load_new", 32'(o_io_new), 0);
    cyc();
    for (int w = 1; w <= 3; w++) begin
      chk("feed_demux", 32'(o_demux_sel), 1);
      chk("feed_wrld", 32'(o_wrld), 2);
      i_cpu_valid = 1'b1;
      #1;
      chk("feed_new", 32'(o_io_new), 1);
      chk("feed_ready", 32'(o_cpu_ready), 1);
      cyc();
      i_cpu_valid = 1'b0;
      #1;
      chk("wait_ready", 32'(o_cpu_ready), 0);
      chk("wait_new", 32'(o_io_new), 0);
      chk("wait_wrld", 32'(o_wrld), 2);
      chk("wait_wf", 32'(o_words_fed), 32'(w));
      cyc(); cyc(); cyc();
      i_decomp_done = 1'b1;
      i_io_finished = (w == 3);
      cyc();
      i_decomp_done = 1'b0;
      i_io_finished = 1'b0;
    end
    chk("settle_wrld", 32'(o_wrld), 0);
    chk("settle_busy", 32'(o_busy), 1);
    n = 1;
    while (!o_ode_enable && n < 50) begin cyc(); n++; end
    chk("count_ode_latency", 32'(n), 8);
    cyc();
    chk("fire_one_cycle", 32'(o_ode_enable), 0);
    chk("fire_idle_busy", 32'(o_busy), 0);
    chk("count_wf", 32'(o_words_fed), 3);

    // Zero count transfer
    i_start = 1'b1; i_cpu_valid = 1'b1;
    cyc();
    i_start = 1'b0; i_cpu_valid = 1'b0; i_io_finished = 1'b1;
    chk("zero_load_wf", 32'(o_words_fed), 0);
    n = 1;
    while (!o_ode_enable && n < 50) begin cyc(); n++; end
    chk("zero_ode_latency", 32'(n), 9);
    chk("zero_wf", 32'(o_words_fed), 0);
    i_io_finished = 1'b0;
    cyc();

    // Decompressor timeout
    i_start = 1'b1; i_cpu_valid = 1'b1;
    cyc();
    i_start = 1'b0; i_cpu_valid = 1'b0;
    cyc();
    i_cpu_valid = 1'b1;
    cyc();
    i_cpu_valid = 1'b0;
    n = 0;
    while (!o_error && n < 400) begin cyc(); n++; end
    chk("timeout_cycles", 32'(n), 255);
    chk("timeout_busy", 32'(o_busy), 0);
    chk("timeout_wrld", 32'(o_wrld), 0);
    chk("timeout_wf", 32'(o_words_fed), 1);
    cyc();
    chk("error_sticky", 32'(o_error), 1);

    // Start pulsed during FEED plus a 5-cycle valid gap
    i_start = 1'b1; i_cpu_valid = 1'b1;
    cyc();
    i_start = 1'b0; i_cpu_valid = 1'b0;
    chk("error_cleared", 32'(o_error), 0);
    cyc();
    i_cpu_valid = 1'b1;
    cyc();
    i_cpu_valid = 1'b0; i_decomp_done = 1'b1;
    cyc();
    i_decomp_done = 1'b0;
    chk("gap_pre_wf", 32'(o_words_fed), 1);
    for (int g = 0; g < 5; g++) begin
      i_start = (g == 1 || g == 2);
      #1;
      chk("gap_new", 32'(o_io_new), 0);
      chk("gap_ready", 32'(o_cpu_ready), 1);
      cyc();
    end
    i_start = 1'b0;
    #1;
    chk("gap_still_feed", 32'(o_cpu_ready), 1);
    chk("gap_wf", 32'(o_words_fed), 1);
    i_cpu_valid = 1'b1;
    #1;
    chk("gap_word2_new", 32'(o_io_new), 1);
    cyc();
    i_cpu_valid = 1'b0; i_decomp_done = 1'b1; i_io_finished = 1'b1;
    cyc();
    i_decomp_done = 1'b0; i_io_finished = 1'b0;
    n = 1;
    while (!o_ode_enable && n < 50) begin cyc(); n++; end
    chk("busy_start_latency", 32'(n), 8);
    chk("busy_start_wf", 32'(o_words_fed), 2);
    cyc();

    // Reset in WAIT_DEC
    i_start = 1'b1; i_cpu_valid = 1'b1;
    cyc();
    i_start = 1'b0; i_cpu_valid = 1'b0;
    cyc();
    i_cpu_valid = 1'b1;
    cyc();
    i_cpu_valid = 1'b0;
    cyc();
    i_rst = 1'b1;
    cyc();
    i_rst = 1'b0;
    chk_reset_vals("rst_wait");

    // Reset in SETTLE
    i_start = 1'b1; i_cpu_valid = 1'b1;
    cyc();
    i_start = 1'b0; i_cpu_valid = 1'b0; i_io_finished = 1'b1;
    cyc(); cyc(); cyc();
    chk("pre_rst_settle_busy", 32'(o_busy), 1);
    i_rst = 1'b1;
    cyc();
    i_rst = 1'b0; i_io_finished = 1'b0;
    chk_reset_vals("rst_settle");
    ode_seen = 0;
    for (int k = 0; k < 15; k++) begin
      cyc();
      if (o_ode_enable) ode_seen++;
    end
    chk("rst_settle_no_ode", 32'(ode_seen), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/io_sequencer.md
IO_SEQUENCER -- requirements
Module: io_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 7: idle cycles between the final word's completion and the ODE enable pulse.
REQ-002 Parameter DEC_TIMEOUT, default 255: maximum cycles in WAIT_DEC before an error is raised.
REQ-003 Parameter CNT_W, default 16: width of the internal words-fed counter.
REQ-004 clk  in  1  single clock; all logic updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  CPU request to begin a transfer; sampled only in IDLE.
REQ-007 cpu_valid  in  1  CPU has a word (count or data) on CPUBus.
REQ-008 cpu_ready  out  1  sequencer accepts the CPUBus word this cycle.
REQ-009 io_finished  in  1  IO down-counter zero flag.
REQ-010 decomp_done  in  1  decompressor single-run finished.
REQ-011 demux_sel  out  1  IO input demux select: 0 = down counter, 1 = decompressor.
REQ-012 io_new  out  1  one-cycle "new word" strobe to the IO block.
REQ-013 wrld  out  2  IO mode: 00 idle, 10 decompress, 01 RAM read-back.
REQ-014 ode_enable  out  1  one-cycle enable pulse to the ODE blocks.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 error  out  1  sticky decompressor-timeout flag.
REQ-017 words_fed  out  CNT_W  count of data words accepted in the current transfer.

Function
REQ-018 States: IDLE, LOAD, FEED, WAIT_DEC, SETTLE, FIRE.
REQ-019 IDLE: cpu_ready = start. start & cpu_valid -> LOAD, with demux_sel=0 and io_new=1 in that same cycle (count word handshake).
REQ-020 LOAD: lasts 1 cycle with demux_sel=0 and io_new=0; then SETTLE if io_finished=1 (zero count), else FEED.
REQ-021 FEED: cpu_ready=1, demux_sel=1, wrld=10.
REQ-022 FEED: cpu_valid=1 -> io_new=1 for that cycle, words_fed+1, then WAIT_DEC.
REQ-023 FEED: cpu_valid=0 -> remain in FEED with no strobe.
REQ-024 WAIT_DEC: cpu_ready=0, demux_sel=1, wrld=10 held, io_new=0.
REQ-025 WAIT_DEC: decomp_done=1 -> SETTLE if io_finished=1 in the same cycle, else FEED.
REQ-026 WAIT_DEC: timeout counter increments each cycle; reaching DEC_TIMEOUT sets error=1 and returns to IDLE.
REQ-027 SETTLE: wrld=00 and exactly SETTLE_CYCLES cycles are spent here, then FIRE.
REQ-028 FIRE: ode_enable=1 for exactly 1 cycle, then IDLE.
REQ-029 Latency: ode_enable rises SETTLE_CYCLES+1 cycles after the completing decomp_done (or after LOAD for a zero count).
REQ-030 IDLE: wrld=00 and demux_sel=0; start ignored while busy=1.
REQ-031 words_fed clears on entry to LOAD and wraps modulo 2^CNT_W.
REQ-032 error clears only on reset or on the next accepted start.
REQ-033 All outputs are registered except cpu_ready and io_new, which are combinational decodes of state, start and cpu_valid.

Reset
REQ-034 rst=1 at any clock edge -> IDLE, including mid-transfer and mid-SETTLE.
REQ-035 Reset values: cpu_ready=0, demux_sel=0, io_new=0, wrld=00, ode_enable=0, busy=0, error=0, words_fed=0; both internal counters cleared.
REQ-036 rst has priority over every other input in the same cycle.

Structure
REQ-037 A shared package holds the state enumeration, the wrld encodings (WRLD_IDLE=00, WRLD_RAM=01, WRLD_DEC=10) and the SETTLE_CYCLES default.
REQ-038 One sub-module, cycle_timer, is a loadable down-counter with a done flag, reused for both SETTLE and the WAIT_DEC timeout.

Verification
REQ-039 Count transfer: start with count=3, three words, decomp_done 4 cycles after each, io_finished on the third -> 3 io_new data strobes, words_fed=3, ode_enable exactly 8 cycles after the third decomp_done.
REQ-040 Zero count: start with count=0 and io_finished=1 -> no data strobes, ode_enable 9 cycles after the count handshake.
REQ-041 Timeout: one word fed, decomp_done withheld -> error=1 after 255 cycles, return to IDLE, busy=0.
REQ-042 Mid-transfer reset: rst asserted in WAIT_DEC and again in SETTLE -> all outputs at reset values next cycle, no ode_enable.
REQ-043 Start while busy: start pulsed during FEED -> ignored, no new count load, transfer completes normally.
REQ-044 cpu_valid gaps: 5-cycle valid gap in FEED -> no io_new during the gap, words_fed unchanged.
